// File: rtl/des_sbox_layer_pkg.sv
// Shared DES S-box constants, the FSM state type and the S-box lookup helper.
// Each table is stored row-major (row*16 + col); the first hex digit is row 0, col 0.
package des_pkg;

  localparam int GRP_W   = 6;
  localparam int NIB_W   = 4;
  localparam int NUM_GRP = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [0:7][0:63][NIB_W-1:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Outer bits select the row, inner four bits the column.
  function automatic logic [NIB_W-1:0] sbox_lookup(input logic [2:0] idx,
                                                  input logic [GRP_W-1:0] six);
    return SBOX[idx][{six[5], six[0], six[4:1]}];
  endfunction

endpackage

// File: rtl/des_sbox_layer_lane.sv
// One S-box evaluator; the caller chooses which of the eight tables to apply.
module des_sbox_lane
  import des_pkg::*;
(
  input  logic [2:0]       sel,
  input  logic [GRP_W-1:0] six,
  output logic [NIB_W-1:0] nib
);

  assign nib = sbox_lookup(sel, six);

endmodule

// File: rtl/des_sbox_layer.sv
// DES S-box substitution layer, LANES S-boxes per cycle, valid/ready on both sides.
// Partial nibbles collect in acc_reg; out_data only updates once the whole word is done.
module des_sbox_layer
  import des_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int         ITERS    = NUM_GRP / LANES;
  localparam logic [2:0] LAST_CNT = 3'(NUM_GRP - LANES);
  localparam logic [2:0] STEP     = 3'(LANES);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("des_sbox_layer: LANES must be 1, 2, 4 or 8 (ITERS=%0d)", ITERS);
  end

  state_t           state_reg, state_next;
  logic [2:0]       grp_cnt_reg;
  logic [47:0]      word_reg;
  logic [NIB_W-1:0] acc_reg [NUM_GRP];
  logic [31:0]      result_reg;

  logic [GRP_W-1:0] grp_bits [NUM_GRP];
  logic [NIB_W-1:0] merged [NUM_GRP];
  logic [31:0]      merged_word;
  logic [2:0]       lane_grp [LANES];
  logic [NIB_W-1:0] lane_nib [LANES];
  logic             accept;
  logic             last_step;

  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
    assign grp_bits[gi]                      = word_reg[47-GRP_W*gi -: GRP_W];
    assign merged_word[31-NIB_W*gi -: NIB_W] = merged[gi];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_grp[gi] = grp_cnt_reg + 3'(gi);
    des_sbox_lane u_lane (
      .sel(lane_grp[gi]),
      .six(grp_bits[lane_grp[gi]]),
      .nib(lane_nib[gi])
    );
  end

  assign in_ready  = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last_step = (grp_cnt_reg == LAST_CNT);
  assign out_valid = (state_reg == ST_DONE);
  assign out_data  = result_reg;

  always_comb begin
    merged = acc_reg;
    for (int k = 0; k < LANES; k++) begin
      merged[lane_grp[k]] = lane_nib[k];
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (accept) state_next = ST_CALC;
      ST_CALC: if (last_step) state_next = ST_DONE;
      ST_DONE: begin
        if (accept)         state_next = ST_CALC;
        else if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      grp_cnt_reg <= '0;
      word_reg    <= '0;
      result_reg  <= '0;
      for (int k = 0; k < NUM_GRP; k++) acc_reg[k] <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        word_reg    <= in_data;
        grp_cnt_reg <= '0;
      end else if (state_reg == ST_CALC) begin
        acc_reg <= merged;
        if (last_step) begin
          grp_cnt_reg <= '0;
          result_reg  <= merged_word;
        end else begin
          grp_cnt_reg <= grp_cnt_reg + STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_sbox_layer.sv
// Runs the same directed and random tests on LANES = 8, 4, 2 and 1 instances in parallel,
// comparing against a row/column model built from the published DES tables.
module tb_des_sbox_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  int sbox_tab [8][4][16] = '{
    '{'{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7},
      '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
      '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0},
      '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13}},
    '{'{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10},
      '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
      '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15},
      '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9}},
    '{'{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8},
      '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
      '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7},
      '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12}},
    '{'{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15},
      '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
      '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4},
      '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14}},
    '{'{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9},
      '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
      '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14},
      '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3}},
    '{'{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
      '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
      '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
      '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}},
    '{'{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1},
      '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
      '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2},
      '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12}},
    '{'{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7},
      '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
      '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8},
      '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}}
  };

  function automatic logic [31:0] ref_sbox(input logic [47:0] w);
    logic [31:0] r;
    int six, row, col;
    r = '0;
    for (int g = 0; g < 8; g++) begin
      six = int'((w >> (42 - 6 * g)) & 48'h3F);
      row = (six / 32) * 2 + (six % 2);
      col = (six / 2) % 16;
      r = (r << 4) | 32'(sbox_tab[g][row][col]);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  for (genvar li = 0; li < 4; li++) begin : g_dut
    localparam int L  = 8 >> li;
    localparam int IT = 8 / L;
    localparam int NW = 1000;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] exp_q[$];

    des_sbox_layer #(.LANES(L)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
    );

    function automatic string tg(input string s);
      return $sformatf("L%0d:%s", L, s);
    endfunction

    // Counts edges from the accepting edge until out_valid, bounded.
    task automatic wait_result(input string nm);
      int lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!out_valid && lat < 40);
      chk(tg({nm, "_lat"}), 48'(lat), 48'(IT));
    endtask

    task automatic drain(input string nm);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk(tg({nm, "_drained"}), 48'(out_valid), 48'd0);
      out_ready = 1'b0;
    endtask

    task automatic run_word(input logic [47:0] d, input logic [31:0] exp, input string nm);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = 1'b0;
      #1;
      chk(tg({nm, "_rdy"}), 48'(in_ready), 48'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk(tg({nm, "_busy"}), 48'({out_valid, in_ready}), 48'd0);
      wait_result(nm);
      chk(tg({nm, "_data"}), 48'(out_data), 48'(exp));
      $display("L%0d %s in=%012h out=%08h", L, nm, d, out_data);
      drain(nm);
    endtask

    task automatic backpressure();
      logic [47:0] d1, d2;
      d1 = {16'($urandom), $urandom};
      d2 = {16'($urandom), $urandom};
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_result("bp1");
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        #1;
        chk(tg("bp_hold"), {15'd0, out_valid, in_ready, out_data}, {15'd0, 1'b1, 1'b0, ref_sbox(d1)});
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d2;
      #1;
      chk(tg("bp_handoff_rdy"), 48'(in_ready), 48'd1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk(tg("bp_handoff_calc"), 48'(out_valid), 48'd0);
      wait_result("bp2");
      chk(tg("bp2_data"), 48'(out_data), 48'(ref_sbox(d2)));
      $display("L%0d backpressure in=%012h out=%08h", L, d2, out_data);
      drain("bp2");
    endtask

    task automatic reset_mid();
      int stale = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 48'hFFFFFFFFFFFF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk(tg("rst_mid_out"), {15'd0, out_valid, out_data}, 48'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk(tg("rst_mid_rdy"), 48'(in_ready), 48'd1);
      for (int i = 0; i < IT + 3; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) stale++;
      end
      chk(tg("rst_mid_stale"), 48'(stale), 48'd0);
      $display("L%0d reset mid-word discarded", L);
    endtask

    task automatic producer();
      logic [47:0] d;
      bit sent;
      int guard;
      for (int i = 0; i < NW; i++) begin
        d     = {16'($urandom), $urandom};
        sent  = 1'b0;
        guard = 0;
        while (!sent && guard < 2000) begin
          @(negedge clk);
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = in_valid ? d : {16'($urandom), $urandom};
          #1;
          if (in_valid && in_ready) begin
            @(posedge clk);
            exp_q.push_back(ref_sbox(d));
            sent = 1'b1;
          end
          guard++;
        end
        if (!sent) chk(tg("stream_send_timeout"), 48'(guard), 48'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
    endtask

    task automatic consumer();
      int got = 0;
      int cyc = 0;
      logic [31:0] seen;
      while (got < NW && cyc < 60000) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (out_valid && out_ready) begin
          seen = out_data;
          @(posedge clk);
          if (exp_q.size() == 0) begin
            chk(tg("stream_unexpected"), 48'(exp_q.size()), 48'd1);
          end else begin
            chk(tg("stream"), 48'(seen), 48'(exp_q.pop_front()));
            $display("L%0d stream %0d out=%08h", L, got, seen);
          end
          got++;
        end
        cyc++;
      end
      chk(tg("stream_count"), 48'(got), 48'(NW));
      @(negedge clk);
      out_ready = 1'b0;
      repeat (IT + 2) @(posedge clk);
      #1;
      chk(tg("stream_leftover"), 48'({exp_q.size(), out_valid}), 48'd0);
    endtask

    initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk(tg("reset_state"), {15'd0, out_valid, in_ready, out_data}, {15'd0, 1'b0, 1'b1, 32'd0});
      @(negedge clk);
      rst_n = 1'b1;

      run_word(48'h0,            32'hEFA72C4D, "zeros");
      run_word(48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "ones");
      run_word(48'h000000040000, 32'hEFA7EC4D, "s5_row1");
      backpressure();
      fork
        producer();
        consumer();
      join
      reset_mid();
      run_word(48'h123456789ABC, ref_sbox(48'h123456789ABC), "after_rst");
      done_cnt++;
    end
  end

  initial begin
    int cyc = 0;
    while (done_cnt < 4 && cyc < 90000) begin
      @(posedge clk);
      cyc++;
    end
    chk("all_lanes_done", 48'(done_cnt), 48'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
